// File: rtl/dual_port_ram_clr.sv
// Two-port read-first RAM with a sweeping clear engine that zeroes every word
// after reset release and on request; port A wins same-address write collisions.
module dual_port_ram_clr #(
  parameter int WIDTH  = 198,
  parameter int DEPTH  = 128,
  parameter int AW     = 7,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_wr,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_din,
  output logic [WIDTH-1:0] a_dout,
  input  logic             b_wr,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_din,
  output logic [WIDTH-1:0] b_dout,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_q, init_d;   // a sweep is owed since the last reset

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] a_rd1, b_rd1, a_pipe, b_pipe;
  logic             a_ok, b_ok, a_we, b_we;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    case (state_q)
      IDLE: begin
        if (clr_req || init_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
          init_d  = 1'b0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign a_ok = ({1'b0, a_addr} < DEPTH_W);
  assign b_ok = ({1'b0, b_addr} < DEPTH_W);
  assign a_we = a_wr && a_ok && !busy;
  assign b_we = b_wr && b_ok && !busy;

  // NOTE: the array has no reset so it maps onto block RAM; the clear engine
  // provides the defined contents instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      if (b_we) mem[b_addr] <= b_din;
      if (a_we) mem[a_addr] <= a_din;  // later assignment: port A wins a collision
    end
  end

  // Reads sample the array before this edge's writes land, giving read-first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rd1 <= '0;
      b_rd1 <= '0;
    end else begin
      a_rd1 <= (busy || !a_ok) ? '0 : mem[a_addr];
      b_rd1 <= (busy || !b_ok) ? '0 : mem[b_addr];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] a_rd2, b_rd2;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_rd2 <= '0;
          b_rd2 <= '0;
        end else begin
          a_rd2 <= a_rd1;
          b_rd2 <= b_rd1;
        end
      end
      assign a_pipe = a_rd2;
      assign b_pipe = b_rd2;
    end else begin : g_lat1
      assign a_pipe = a_rd1;
      assign b_pipe = b_rd1;
    end
  endgenerate

  // Outputs read as zero for the whole time the clear engine owns the memory.
  assign a_dout = busy ? '0 : a_pipe;
  assign b_dout = busy ? '0 : b_pipe;

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Scoreboard bench: two RAM configurations (128/lat1 and 100/lat2) share one
// stimulus stream; an array-based reference model predicts every output.
module tb_dual_port_ram_clr;

  localparam int W  = 198;
  localparam int AW = 7;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_wr, b_wr, clr_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_din, b_din;
  logic [W-1:0]  a_dout0, b_dout0, a_dout1, b_dout1;
  logic          busy0, busy1;

  always #5 clk = ~clk;

  dual_port_ram_clr u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0),
    .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0),
    .clr_req(clr_req), .busy(busy0)
  );

  dual_port_ram_clr #(.WIDTH(W), .DEPTH(100), .AW(AW), .RD_LAT(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1),
    .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1),
    .clr_req(clr_req), .busy(busy1)
  );

  // Reference model state, one slot per configuration.
  logic [W-1:0] mem_m [2][128];
  int           busy_left [2];
  bit           init_pend [2];
  bit           model_busy [2];
  bit           in_reset;
  exp_t         q0[$];
  exp_t         q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? 128 : 100;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [223:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // One access cycle: reads see old contents, A overrides B, a busy memory
  // blocks everything, and a clear simply zeroes the whole model array.
  task automatic model_step(input int d);
    exp_t e;
    int   ai, bi, dep;
    bit   busy_now;
    ai = int'(a_addr);
    bi = int'(b_addr);
    dep = depth_of(d);
    busy_now = (busy_left[d] > 0);
    e.a = '0;
    e.b = '0;
    if (!busy_now) begin
      if (ai < dep) e.a = mem_m[d][ai];
      if (bi < dep) e.b = mem_m[d][bi];
      if (b_wr && bi < dep) mem_m[d][bi] = b_din;
      if (a_wr && ai < dep) mem_m[d][ai] = a_din;
    end
    if (busy_now) begin
      busy_left[d]--;
    end else if (clr_req || init_pend[d]) begin
      busy_left[d] = dep + 1;
      init_pend[d] = 1'b0;
      for (int i = 0; i < 128; i++) mem_m[d][i] = '0;
    end
    model_busy[d] = (busy_left[d] > 0);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input bit awr, input int aad, input logic [W-1:0] ad,
                       input bit bwr, input int bad, input logic [W-1:0] bd,
                       input bit clr);
    @(negedge clk);
    a_wr = awr; a_addr = AW'(aad); a_din = ad;
    b_wr = bwr; b_addr = AW'(bad); b_din = bd;
    clr_req = clr;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_reset = 1'b1;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      busy_left[d]  = 0;
      init_pend[d]  = 1'b1;
      model_busy[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_a_dout0", a_dout0, '0);
    check("rst_b_dout0", b_dout0, '0);
    check("rst_a_dout1", a_dout1, '0);
    check("rst_b_dout1", b_dout1, '0);
    check("rst_busy0", W'(busy0), '0);
    check("rst_busy1", W'(busy1), '0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    a_wr = 1'b0; b_wr = 1'b0; clr_req = 1'b0;
    a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
    model_step(0);
    model_step(1);
    in_reset = 1'b0;
  endtask

  // Counts busy cycles of both instances over a fixed window; optionally
  // hammers both write ports during the first 129 cycles of the window.
  task automatic count_busy(input bit junk, input int exp0, input int exp1);
    int n0 = 0;
    int n1 = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (busy0) n0++;
      if (busy1) n1++;
      if (junk && i <= 128)
        drive(1'b1, $urandom_range(0, 127), rand_word(), 1'b1, $urandom_range(0, 127), rand_word(), 1'b0);
      else
        idle();
    end
    check("busy_len0", W'(n0), W'(exp0));
    check("busy_len1", W'(n1), W'(exp1));
  endtask

  task automatic read_sweep();
    for (int i = 0; i < 128; i++)
      drive(1'b0, i, '0, 1'b0, 127 - i, '0, 1'b0);
    repeat (3) idle();
  endtask

  // Monitor: compares busy every cycle and pops one expected read per cycle
  // once the configuration's read latency has elapsed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!in_reset) begin
        check("busy0", W'(busy0), W'(model_busy[0]));
        check("busy1", W'(busy1), W'(model_busy[1]));
        if (q0.size() >= 1) begin
          e = q0.pop_front();
          check("a_dout0", a_dout0, model_busy[0] ? '0 : e.a);
          check("b_dout0", b_dout0, model_busy[0] ? '0 : e.b);
        end
        if (q1.size() >= 2) begin
          e = q1.pop_front();
          check("a_dout1", a_dout1, model_busy[1] ? '0 : e.a);
          check("b_dout1", b_dout1, model_busy[1] ? '0 : e.b);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_reset = 1'b1;
    a_wr = 1'b0; b_wr = 1'b0; clr_req = 1'b0;
    a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 128; i++) mem_m[d][i] = '0;

    // Power-on clear and zero read-back.
    assert_reset();
    release_reset();
    count_busy(1'b0, 129, 101);
    read_sweep();

    // Read-first on the writing port; next-cycle read sees the new value.
    drive(1'b1, 5, W'(3), 1'b0, 5, '0, 1'b0);
    drive(1'b0, 5, '0, 1'b0, 5, '0, 1'b0);
    // Same-address collision: A data is kept.
    drive(1'b1, 9, W'('hAA), 1'b1, 9, W'('h55), 1'b0);
    drive(1'b0, 9, '0, 1'b0, 9, '0, 1'b0);
    // Cross-port read during a write returns old data, then new data.
    drive(1'b1, 1, rand_word(), 1'b0, 1, '0, 1'b0);
    drive(1'b0, 0, '0, 1'b0, 1, '0, 1'b0);
    // Writes above the smaller configuration's depth.
    drive(1'b1, 100, rand_word(), 1'b1, 127, rand_word(), 1'b0);
    drive(1'b0, 100, '0, 1'b0, 127, '0, 1'b0);
    repeat (3) idle();

    // Randomized traffic biased towards a few addresses to force collisions.
    for (int i = 0; i < 600; i++) begin
      int aa, ba;
      aa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 7);
      ba = ($urandom_range(0, 3) == 0) ? aa : $urandom_range(0, 7);
      drive($urandom_range(0, 1) == 1, aa, rand_word(),
            $urandom_range(0, 1) == 1, ba, rand_word(),
            $urandom_range(0, 249) == 0);
    end
    repeat (140) idle();

    // Fill with 0x1, then clear on request with writes hammered during busy.
    for (int i = 0; i < 64; i++)
      drive(1'b1, 2 * i, W'(1), 1'b1, 2 * i + 1, W'(1), 1'b0);
    read_sweep();
    drive(1'b0, 0, '0, 1'b0, 0, '0, 1'b1);
    count_busy(1'b1, 129, 101);
    read_sweep();

    // Reset in the middle of a sweep restarts a full sweep from address 0.
    for (int i = 0; i < 64; i++)
      drive(1'b1, 2 * i, rand_word(), 1'b1, 2 * i + 1, rand_word(), 1'b0);
    assert_reset();
    release_reset();
    repeat (41) idle();
    assert_reset();
    release_reset();
    count_busy(1'b0, 129, 101);
    read_sweep();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_clr.md
DUAL_PORT_RAM_CLR -- requirements
Module: dual_port_ram_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 198, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, number of words; legal range 2..4096.
REQ-003 SHALL have parameter AW, default 7, address width, equal to ceil(log2(DEPTH)).
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic uses the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports a_wr (input, 1), a_addr (input, AW), a_din (input, WIDTH) and a_dout (output, WIDTH) for port A.
REQ-008 SHALL have ports b_wr (input, 1), b_addr (input, AW), b_din (input, WIDTH) and b_dout (output, WIDTH) for port B.
REQ-009 SHALL have port clr_req, input, 1 bit: a one-cycle pulse that starts a full-memory clear.
REQ-010 SHALL have port busy, output, 1 bit: high while the clear engine owns the memory.

Function
REQ-011 Each port SHALL perform an access on every cycle: a write when x_wr=1, otherwise a read of x_addr.
REQ-012 With RD_LAT=1, x_dout SHALL present mem[x_addr] one cycle after the address is sampled; with RD_LAT=2, through one extra output register, two cycles after.
REQ-013 A port writing SHALL still update x_dout with the old contents of x_addr (read-first).
REQ-014 A cross-port read of an address being written in the same cycle SHALL return the old contents.
REQ-015 When both ports write the same address in the same cycle, port A data SHALL be stored and port B data discarded.
REQ-016 x_addr >= DEPTH SHALL be ignored on write, and SHALL return zero on read.
REQ-017 The clear engine SHALL have states IDLE, CLEAR and DONE.
REQ-018 In IDLE, the clear engine SHALL move to CLEAR on clr_req=1.
REQ-019 In CLEAR, the clear engine SHALL write zero to address cnt, incrementing cnt from 0 to DEPTH-1, one word per cycle.
REQ-020 After writing DEPTH-1, the clear engine SHALL enter DONE for one cycle, then return to IDLE.
REQ-021 busy SHALL be 1 in CLEAR and DONE, and 0 in IDLE; a clear takes DEPTH+1 busy cycles.
REQ-022 While busy=1, a_wr and b_wr SHALL be ignored, and a_dout and b_dout SHALL read as zero.
REQ-023 clr_req asserted while busy=1 SHALL be ignored; no queuing and no restart.
REQ-024 The clear counter SHALL be AW bits wide and SHALL NOT wrap past DEPTH-1 for non-power-of-two DEPTH.
REQ-025 The memory SHALL be inferable as block RAM: the array itself is not reset, and only the control and output registers are.

Reset
REQ-026 On reset_n=0, a_dout, b_dout and every pipeline register SHALL asynchronously go to zero.
REQ-027 On reset_n=0, the clear engine SHALL go to IDLE and cnt to zero.
REQ-028 On release of reset_n, the clear engine SHALL automatically enter CLEAR on the first rising edge, so busy=1 from that edge for DEPTH+1 cycles.
REQ-029 A reset asserted mid-clear SHALL abort the sweep; after release, a full new sweep SHALL start from address 0.
REQ-030 Memory contents SHALL be undefined only before the first completed clear; thereafter they are defined by writes and clears.

Verification
REQ-031 Defaults, release reset -> busy=1 for exactly 129 cycles; afterwards reading addresses 0..127 on both ports returns 0.
REQ-032 Port A writes 0x3 to address 5, then reads address 5 on the next cycle -> a_dout=0x3 one cycle later (two cycles later with RD_LAT=2); the read on the write cycle itself returns 0.
REQ-033 Same-cycle writes A=0xAA and B=0x55 to address 9 -> a subsequent read of 9 on either port returns 0xAA.
REQ-034 A writes address 1 while B reads address 1 in the same cycle -> b_dout shows the old value, and the next B read shows the new value.
REQ-035 clr_req pulse with memory filled with 0x1 -> busy high for 129 cycles, a_wr ignored throughout, then all words read 0.
REQ-036 reset_n pulsed low at cnt=40, then DEPTH=100 and RD_LAT=2 -> busy high for 101 cycles after release, all 100 words zero, and no write to address 100 or above.
